// File: rtl/framebuffer_arbiter.sv
// Round-robin write arbiter in front of a single framebuffer BRAM write port,
// with a full-frame clear engine that runs between channel bursts.
module framebuffer_arbiter #(
    parameter int NUM_CH          = 4,
    parameter int FBUF_ADDR_WIDTH = 19,
    parameter int FBUF_DATA_WIDTH = 8,
    parameter int FBUF_DEPTH      = 307200,
    parameter int BURST_MAX       = 256,
    parameter logic [FBUF_DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_CH-1:0]                   ch_req,
    output logic [NUM_CH-1:0]                   ch_grant,
    input  logic [NUM_CH-1:0]                   ch_valid,
    output logic [NUM_CH-1:0]                   ch_ready,
    input  logic [NUM_CH*FBUF_ADDR_WIDTH-1:0]   ch_addr,
    input  logic [NUM_CH*FBUF_DATA_WIDTH-1:0]   ch_data,
    input  logic [NUM_CH-1:0]                   ch_clr_req,
    output logic                                busy,
    output logic                                clr_done,
    output logic                                fbuf_en_wr,
    output logic                                fbuf_wrea,
    output logic [FBUF_ADDR_WIDTH-1:0]          fbuf_addr,
    output logic [FBUF_DATA_WIDTH-1:0]          fbuf_data
);

    localparam int PTR_W  = $clog2(NUM_CH);
    localparam int BEAT_W = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
    localparam int CLR_W  = (FBUF_DEPTH > 1) ? $clog2(FBUF_DEPTH) : 1;
    localparam logic [BEAT_W-1:0]        BEAT_LAST = BEAT_W'(BURST_MAX - 1);
    localparam logic [CLR_W-1:0]         CLR_LAST  = CLR_W'(FBUF_DEPTH - 1);
    localparam logic [FBUF_ADDR_WIDTH:0] DEPTH_A   = FBUF_DEPTH[FBUF_ADDR_WIDTH:0];
    localparam logic [PTR_W-1:0]         PTR_INIT  = PTR_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN   = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    state_t                     state_r, state_s;
    logic [NUM_CH-1:0]          grant_s;
    logic [PTR_W-1:0]           rr_ptr_r, rr_ptr_s;
    logic [BEAT_W-1:0]          beat_cnt_r, beat_cnt_s;
    logic [CLR_W-1:0]           clr_cnt_r, clr_cnt_s;
    logic                       clr_pending_r, clr_pending_s;
    logic                       wr_en_s, clr_done_s;
    logic [FBUF_ADDR_WIDTH-1:0] wr_addr_s;
    logic [FBUF_DATA_WIDTH-1:0] wr_data_s;
    logic                       pick_found_s;
    logic [PTR_W-1:0]           pick_idx_s, cand_s;
    logic [NUM_CH-1:0]          pick_onehot_s;
    logic                       accept_s, addr_ok_s;
    logic [FBUF_ADDR_WIDTH-1:0] addr_arr_s [NUM_CH];
    logic [FBUF_DATA_WIDTH-1:0] data_arr_s [NUM_CH];

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
        assign addr_arr_s[gi] = ch_addr[gi*FBUF_ADDR_WIDTH +: FBUF_ADDR_WIDTH];
        assign data_arr_s[gi] = ch_data[gi*FBUF_DATA_WIDTH +: FBUF_DATA_WIDTH];
    end

    assign ch_ready  = ch_grant & {NUM_CH{state_r == ST_OWN}};
    assign busy      = (state_r == ST_CLEAR);
    assign accept_s  = ch_valid[rr_ptr_r] & ch_ready[rr_ptr_r];
    assign addr_ok_s = ({1'b0, addr_arr_s[rr_ptr_r]} < DEPTH_A);

    // Round-robin search starting one past the last granted channel
    always_comb begin
        pick_found_s = 1'b0;
        pick_idx_s   = '0;
        cand_s       = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand_s = PTR_W'((int'(rr_ptr_r) + k) % NUM_CH);
            if (!pick_found_s && ch_req[cand_s]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = cand_s;
            end else begin
                pick_found_s = pick_found_s;
            end
        end
        pick_onehot_s = {{(NUM_CH-1){1'b0}}, 1'b1} << pick_idx_s;
    end

    // Next-state, counters and write-port values
    always_comb begin
        state_s       = state_r;
        grant_s       = ch_grant;
        rr_ptr_s      = rr_ptr_r;
        beat_cnt_s    = beat_cnt_r;
        clr_cnt_s     = clr_cnt_r;
        clr_pending_s = clr_pending_r;
        wr_en_s       = 1'b0;
        wr_addr_s     = fbuf_addr;
        wr_data_s     = fbuf_data;
        clr_done_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (clr_pending_r || (|ch_clr_req)) begin
                    state_s       = ST_CLEAR;
                    clr_pending_s = 1'b0;
                    clr_cnt_s     = '0;
                end else if (pick_found_s) begin
                    state_s    = ST_OWN;
                    grant_s    = pick_onehot_s;
                    rr_ptr_s   = pick_idx_s;
                    beat_cnt_s = '0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_OWN: begin
                clr_pending_s = clr_pending_r | (|ch_clr_req);
                if (accept_s) begin
                    wr_en_s    = addr_ok_s;
                    beat_cnt_s = beat_cnt_r + BEAT_W'(1);
                    if (addr_ok_s) begin
                        wr_addr_s = addr_arr_s[rr_ptr_r];
                        wr_data_s = data_arr_s[rr_ptr_r];
                    end else begin
                        wr_addr_s = fbuf_addr;
                    end
                end else begin
                    wr_en_s = 1'b0;
                end
                // The closing beat is still written; only ownership ends here
                if (!ch_req[rr_ptr_r] || (accept_s && (beat_cnt_r == BEAT_LAST))) begin
                    state_s    = ST_IDLE;
                    grant_s    = '0;
                    beat_cnt_s = '0;
                end else begin
                    state_s = ST_OWN;
                end
            end
            ST_CLEAR: begin
                wr_en_s   = 1'b1;
                wr_addr_s = FBUF_ADDR_WIDTH'(clr_cnt_r);
                wr_data_s = CLEAR_VALUE;
                if (clr_cnt_r == CLR_LAST) begin
                    state_s    = ST_IDLE;
                    clr_cnt_s  = '0;
                    clr_done_s = 1'b1;
                end else begin
                    clr_cnt_s = clr_cnt_r + CLR_W'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                grant_s = '0;
            end
        endcase
    end

    // State and registered BRAM write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            ch_grant      <= '0;
            rr_ptr_r      <= PTR_INIT;
            beat_cnt_r    <= '0;
            clr_cnt_r     <= '0;
            clr_pending_r <= 1'b0;
            clr_done      <= 1'b0;
            fbuf_en_wr    <= 1'b0;
            fbuf_wrea     <= 1'b0;
            fbuf_addr     <= '0;
            fbuf_data     <= '0;
        end else begin
            state_r       <= state_s;
            ch_grant      <= grant_s;
            rr_ptr_r      <= rr_ptr_s;
            beat_cnt_r    <= beat_cnt_s;
            clr_cnt_r     <= clr_cnt_s;
            clr_pending_r <= clr_pending_s;
            clr_done      <= clr_done_s;
            fbuf_en_wr    <= wr_en_s;
            fbuf_wrea     <= wr_en_s;
            fbuf_addr     <= wr_addr_s;
            fbuf_data     <= wr_data_s;
        end
    end

endmodule

// File: tb/tb_framebuffer_arbiter.sv
// Directed bench for framebuffer_arbiter: arbitration order, bursts, range
// filtering, deferred clear, clear priority and reset abort.
module tb_framebuffer_arbiter;

    localparam int NUM_CH = 4;
    localparam int AW     = 8;
    localparam int DW     = 8;
    localparam int DEPTH  = 16;
    localparam int BMAX   = 4;
    localparam logic [DW-1:0] CLRV = 8'h3C;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NUM_CH-1:0]      ch_req, ch_grant, ch_valid, ch_ready, ch_clr_req;
    logic [NUM_CH*AW-1:0]   ch_addr;
    logic [NUM_CH*DW-1:0]   ch_data;
    logic                   busy, clr_done, fbuf_en_wr, fbuf_wrea;
    logic [AW-1:0]          fbuf_addr;
    logic [DW-1:0]          fbuf_data;

    int n_cmp = 0;
    int n_err = 0;
    logic [DW-1:0] burst_data [4] = '{8'hA5, 8'h11, 8'h22, 8'h33};

    framebuffer_arbiter #(
        .NUM_CH(NUM_CH), .FBUF_ADDR_WIDTH(AW), .FBUF_DATA_WIDTH(DW),
        .FBUF_DEPTH(DEPTH), .BURST_MAX(BMAX), .CLEAR_VALUE(CLRV)
    ) dut (
        .clk(clk), .rst(rst), .ch_req(ch_req), .ch_grant(ch_grant),
        .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_addr(ch_addr),
        .ch_data(ch_data), .ch_clr_req(ch_clr_req), .busy(busy),
        .clr_done(clr_done), .fbuf_en_wr(fbuf_en_wr), .fbuf_wrea(fbuf_wrea),
        .fbuf_addr(fbuf_addr), .fbuf_data(fbuf_data)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        ch_addr[i*AW +: AW] = a;
        ch_data[i*DW +: DW] = d;
    endtask

    initial begin
        int done_seen;
        int wr_seen;
        rst = 1'b1; ch_req = '0; ch_valid = '0; ch_clr_req = '0;
        ch_addr = '0; ch_data = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_grant", 32'(ch_grant), 32'h0);
        check_eq("rst_ready", 32'(ch_ready), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_done", 32'(clr_done), 32'h0);
        check_eq("rst_en", 32'({fbuf_en_wr, fbuf_wrea}), 32'h0);
        check_eq("rst_addr", 32'(fbuf_addr), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Round robin: ch1 first, then ch3 after one idle cycle
        ch_req = 4'b1010;
        @(negedge clk);
        check_eq("rr_first", 32'(ch_grant), 32'h2);
        check_eq("rr_ready", 32'(ch_ready), 32'h2);
        ch_req = 4'b1000;
        @(negedge clk);
        check_eq("rr_idle_gap", 32'(ch_grant), 32'h0);
        @(negedge clk);
        check_eq("rr_second", 32'(ch_grant), 32'h8);
        ch_req = 4'b0000;
        @(negedge clk);
        check_eq("rr_release", 32'(ch_grant), 32'h0);

        // ch0 burst of BURST_MAX beats
        ch_req = 4'b0001; ch_valid = 4'b0001; set_ch(0, 8'd5, 8'hA5);
        @(negedge clk);
        check_eq("burst_grant", 32'(ch_grant), 32'h1);
        check_eq("burst_no_wr_yet", 32'(fbuf_en_wr), 32'h0);
        for (int b = 0; b < 4; b++) begin
            set_ch(0, AW'(5 + b), burst_data[b]);
            @(negedge clk);
            check_eq("burst_en", 32'({fbuf_en_wr, fbuf_wrea}), 32'h3);
            check_eq("burst_addr", 32'(fbuf_addr), 32'(5 + b));
            check_eq("burst_data", 32'(fbuf_data), 32'(burst_data[b]));
            check_eq("burst_grant_b", 32'(ch_grant), (b == 3) ? 32'h0 : 32'h1);
        end
        @(negedge clk);
        check_eq("regrant_en", 32'(fbuf_en_wr), 32'h0);
        check_eq("hold_addr", 32'(fbuf_addr), 32'd8);
        check_eq("regrant", 32'(ch_grant), 32'h1);
        ch_req = '0; ch_valid = '0;
        @(negedge clk);
        check_eq("regrant_rel", 32'(ch_grant), 32'h0);

        // Out-of-range beat is consumed but not written
        ch_req = 4'b0001;
        @(negedge clk);
        check_eq("oor_grant", 32'(ch_grant), 32'h1);
        set_ch(0, 8'd16, 8'h77); ch_valid = 4'b0001;
        check_eq("oor_ready", 32'(ch_ready), 32'h1);
        @(negedge clk);
        check_eq("oor_en", 32'({fbuf_en_wr, fbuf_wrea}), 32'h0);
        check_eq("oor_hold_addr", 32'(fbuf_addr), 32'd8);
        ch_req = '0; ch_valid = '0;
        @(negedge clk);

        // Clear requested during ownership waits for release
        ch_req = 4'b0001;
        @(negedge clk);
        ch_clr_req = 4'b0100;
        @(negedge clk);
        ch_clr_req = '0;
        check_eq("defer_busy", 32'(busy), 32'h0);
        check_eq("defer_grant", 32'(ch_grant), 32'h1);
        @(negedge clk);
        check_eq("defer_grant2", 32'(ch_grant), 32'h1);
        ch_req = '0;
        @(negedge clk);
        check_eq("defer_rel_busy", 32'(busy), 32'h0);
        @(negedge clk);
        check_eq("clr_busy", 32'(busy), 32'h1);
        check_eq("clr_ready", 32'(ch_ready), 32'h0);
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            check_eq("clr_en", 32'({fbuf_en_wr, fbuf_wrea}), 32'h3);
            check_eq("clr_addr", 32'(fbuf_addr), 32'(i));
            check_eq("clr_data", 32'(fbuf_data), 32'(CLRV));
            check_eq("clr_done", 32'(clr_done), (i == DEPTH - 1) ? 32'h1 : 32'h0);
            check_eq("clr_busy_i", 32'(busy), (i == DEPTH - 1) ? 32'h0 : 32'h1);
        end
        @(negedge clk);
        check_eq("clr_after_en", 32'(fbuf_en_wr), 32'h0);
        check_eq("clr_after_done", 32'(clr_done), 32'h0);

        // Clear and request together: clear first; clear request inside CLEAR ignored
        ch_clr_req = 4'b0001; ch_req = 4'b0010;
        @(negedge clk);
        ch_clr_req = '0;
        check_eq("prio_busy", 32'(busy), 32'h1);
        check_eq("prio_grant", 32'(ch_grant), 32'h0);
        for (int i = 0; i < DEPTH; i++) begin
            ch_clr_req = (i == 3) ? 4'b1000 : 4'b0000;
            @(negedge clk);
            check_eq("prio_addr", 32'(fbuf_addr), 32'(i));
            check_eq("prio_grant_i", 32'(ch_grant), 32'h0);
        end
        ch_clr_req = '0;
        @(negedge clk);
        check_eq("prio_after_grant", 32'(ch_grant), 32'h2);
        check_eq("prio_after_busy", 32'(busy), 32'h0);
        ch_req = '0;
        @(negedge clk);

        // Reset in the middle of a clear
        ch_clr_req = 4'b0001;
        @(negedge clk);
        ch_clr_req = '0;
        repeat (8) @(negedge clk);
        check_eq("mid_addr", 32'(fbuf_addr), 32'd7);
        rst = 1'b1;
        #1;
        check_eq("abort_en", 32'({fbuf_en_wr, fbuf_wrea}), 32'h0);
        check_eq("abort_addr", 32'(fbuf_addr), 32'h0);
        check_eq("abort_data", 32'(fbuf_data), 32'h0);
        check_eq("abort_busy", 32'(busy), 32'h0);
        check_eq("abort_done", 32'(clr_done), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0; wr_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            done_seen += int'(clr_done);
            wr_seen   += int'(fbuf_en_wr) + int'(busy);
        end
        check_eq("abort_no_done", 32'(done_seen), 32'h0);
        check_eq("abort_no_write", 32'(wr_seen), 32'h0);
        ch_req = 4'b1111;
        @(negedge clk);
        check_eq("abort_first_grant", 32'(ch_grant), 32'h1);
        ch_req = '0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
